// File: rtl/ra_builder.sv
// Region Array builder: writes one RA entry (control word + OL pointers) per tile into VRAM.
// Define RA_BUILDER_OL_INIT_EN to also terminate each tile's object lists with an EOL link.
module ra_builder #(
  parameter int ADDR_W = 24
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ra_build_trig,
  input  logic [31:0]       FPU_PARAM_CFG,
  input  logic [31:0]       TA_ALLOC_CTRL,
  input  logic [31:0]       TA_GLOB_TILE_CLIP,
  input  logic [31:0]       REGION_BASE,
  input  logic [31:0]       TA_OL_BASE,
  input  logic [31:0]       PARAM_BASE,
  output logic              ra_vram_wr,
  output logic [ADDR_W-1:0] ra_vram_addr,
  output logic [31:0]       ra_vram_dout,
  input  logic              ra_vram_wait,
  output logic              ra_busy,
  output logic              ra_done
);
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_CTRL, S_PTR, S_OLI, S_NEXT, S_DONE} state_t;

  state_t                   state, state_nx;
  logic                     v2;
  logic [4:0][1:0]          code;
  logic [4:0]               en;
  logic [5:0]               tx_m1, x;
  logic [3:0]               ty_m1, y;
  logic [10:0]              n_tiles;
  logic [2:0]               idx, ptr_last, ol_sel;
  logic [4:0][ADDR_W-1:0]   ptr;
  logic [ADDR_W-1:0]        run_base, wr_addr, param_base, list_bytes;
  logic [4:0]               ol_pend, ol_rest;
  logic                     accept, last_tile;

  logic unused_bits;
  assign unused_bits = ^{FPU_PARAM_CFG[31:22], FPU_PARAM_CFG[20:0], TA_ALLOC_CTRL[31:18],
                         TA_ALLOC_CTRL[15:14], TA_ALLOC_CTRL[11:10], TA_ALLOC_CTRL[7:6],
                         TA_ALLOC_CTRL[3:2], TA_GLOB_TILE_CLIP[31:20], TA_GLOB_TILE_CLIP[15:6],
                         REGION_BASE[31:23], TA_OL_BASE[31:ADDR_W], PARAM_BASE[31:ADDR_W]};

  assign accept     = ra_vram_wr & ~ra_vram_wait;
  assign last_tile  = (x == tx_m1) && (y == ty_m1);
  assign ptr_last   = v2 ? 3'd4 : 3'd3;
  assign ol_rest    = ol_pend & (ol_pend - 5'd1);
  // Whole list area for one type: N tiles * (16 << code) bytes.
  assign list_bytes = en[idx] ? (ADDR_W'(n_tiles) << (4 + code[idx])) : '0;
  assign ra_busy    = (state != S_IDLE) && (state != S_DONE);
  assign ra_done    = (state == S_DONE);

  always_comb begin
    ol_sel = 3'd0;
    for (int i = 4; i >= 0; i--)
      if (ol_pend[i]) ol_sel = 3'(i);
  end

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;

  always_comb begin
    state_nx     = state;
    ra_vram_wr   = 1'b0;
    ra_vram_addr = '0;
    ra_vram_dout = '0;
    case (state)
      S_IDLE:  if (ra_build_trig) state_nx = S_SETUP;
      S_SETUP: if (idx == 3'd4) state_nx = S_CTRL;
      S_CTRL: begin
        ra_vram_wr   = 1'b1;
        ra_vram_addr = wr_addr;
        ra_vram_dout = {last_tile, 17'd0, 2'd0, y, x, 2'd0};
        if (accept) state_nx = S_PTR;
      end
      S_PTR: begin
        ra_vram_wr   = 1'b1;
        ra_vram_addr = wr_addr;
        ra_vram_dout = en[idx] ? 32'(ptr[idx]) : 32'h8000_0000;
        if (accept && idx == ptr_last) begin
`ifdef RA_BUILDER_OL_INIT_EN
          state_nx = (|ol_pend) ? S_OLI : S_NEXT;
`else
          state_nx = S_NEXT;
`endif
        end
      end
      S_OLI: begin
        ra_vram_wr   = 1'b1;
        ra_vram_addr = param_base + ptr[ol_sel];
        ra_vram_dout = 32'hF000_0000;
        if (accept && ol_rest == '0) state_nx = S_NEXT;
      end
      S_NEXT:  state_nx = last_tile ? S_DONE : S_CTRL;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v2 <= 1'b0; code <= '0; en <= '0; tx_m1 <= '0; ty_m1 <= '0; n_tiles <= '0;
      x <= '0; y <= '0; idx <= '0; ptr <= '0; run_base <= '0; wr_addr <= '0;
      param_base <= '0; ol_pend <= '0;
    end else begin
      case (state)
        S_IDLE: if (ra_build_trig) begin
          v2         <= FPU_PARAM_CFG[21];
          code       <= {TA_ALLOC_CTRL[17:16], TA_ALLOC_CTRL[13:12], TA_ALLOC_CTRL[9:8],
                         TA_ALLOC_CTRL[5:4], TA_ALLOC_CTRL[1:0]};
          en         <= {FPU_PARAM_CFG[21] & |TA_ALLOC_CTRL[17:16], |TA_ALLOC_CTRL[13:12],
                         |TA_ALLOC_CTRL[9:8], |TA_ALLOC_CTRL[5:4], |TA_ALLOC_CTRL[1:0]};
          tx_m1      <= TA_GLOB_TILE_CLIP[5:0];
          ty_m1      <= TA_GLOB_TILE_CLIP[19:16];
          n_tiles    <= (11'(TA_GLOB_TILE_CLIP[5:0]) + 11'd1) * (11'(TA_GLOB_TILE_CLIP[19:16]) + 11'd1);
          run_base   <= TA_OL_BASE[ADDR_W-1:0] - PARAM_BASE[ADDR_W-1:0];
          param_base <= PARAM_BASE[ADDR_W-1:0];
          wr_addr    <= ADDR_W'(REGION_BASE[22:0]);
          x <= '0; y <= '0; idx <= '0;
        end
        S_SETUP: begin
          ptr[idx] <= run_base;
          run_base <= run_base + list_bytes;
          idx      <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
        end
        S_CTRL: if (accept) begin
          wr_addr <= wr_addr + ADDR_W'(4);
          idx     <= '0;
          ol_pend <= en;
        end
        S_PTR: if (accept) begin
          wr_addr <= wr_addr + ADDR_W'(4);
          idx     <= idx + 3'd1;
        end
        S_OLI: if (accept) ol_pend <= ol_rest;
        S_NEXT: begin
          for (int i = 0; i < 5; i++)
            if (en[i]) ptr[i] <= ptr[i] + (ADDR_W'(16) << code[i]);
          if (x == tx_m1) begin
            x <= '0;
            y <= y + 4'd1;
          end else begin
            x <= x + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ra_builder.sv
// Directed bench for ra_builder: expected VRAM writes queued at stimulus time, popped on each accepted write.
module tb_ra_builder;
  logic        clock = 1'b0, reset_n = 1'b0, ra_build_trig = 1'b0, ra_vram_wait = 1'b0;
  logic [31:0] fpu = '0, alloc = '0, clip = '0, region = '0, olb = '0, pb = '0;
  logic        ra_vram_wr, ra_busy, ra_done;
  logic [23:0] ra_vram_addr;
  logic [31:0] ra_vram_dout;

  typedef struct packed { logic [23:0] a; logic [31:0] d; } wr_t;
  wr_t exp_q[$];

  int vectors = 0, errs = 0, cyc = 0, acc_cnt = 0, done_cnt = 0;
  int first_acc = 0, done_cyc = 0, acc_mark = 0;

  ra_builder dut (
    .clock(clock), .reset_n(reset_n), .ra_build_trig(ra_build_trig),
    .FPU_PARAM_CFG(fpu), .TA_ALLOC_CTRL(alloc), .TA_GLOB_TILE_CLIP(clip),
    .REGION_BASE(region), .TA_OL_BASE(olb), .PARAM_BASE(pb),
    .ra_vram_wr(ra_vram_wr), .ra_vram_addr(ra_vram_addr), .ra_vram_dout(ra_vram_dout),
    .ra_vram_wait(ra_vram_wait), .ra_busy(ra_busy), .ra_done(ra_done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  // Writes are accepted at the next rising edge; inputs only change just after rising edges.
  always @(negedge clock) if (reset_n) begin
    if (ra_done) begin done_cnt++; done_cyc = cyc; end
    if (ra_vram_wr && !ra_vram_wait) begin
      wr_t e;
      if (acc_cnt == acc_mark) first_acc = cyc;
      acc_cnt++;
      vectors++;
      if (exp_q.size() == 0) begin
        assert (0) else begin
          errs++;
          $error("FAIL unexpected_wr: got %h@%h required none", ra_vram_dout, ra_vram_addr);
        end
      end else begin
        e = exp_q.pop_front();
        assert (ra_vram_addr === e.a && ra_vram_dout === e.d) else begin
          errs++;
          $error("FAIL wr: got %h@%h required %h@%h", ra_vram_dout, ra_vram_addr, e.d, e.a);
        end
      end
    end
  end

  task automatic tick; @(posedge clock); #1; endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [23:0] a, input logic [31:0] d);
    exp_q.push_back('{a: a, d: d});
  endtask

  task automatic start;
    ra_build_trig = 1'b1; tick; ra_build_trig = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string tag);
    int n = 0;
    while (done_cnt == d0 && n < 2000) begin tick; n++; end
    repeat (4) tick;
    check({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_busy"}, {31'd0, ra_busy}, 32'd0);
    check({tag, "_qempty"}, 32'(exp_q.size()), 32'd0);
  endtask

  // v2, 2x2 tiles, o=32B, t=32B, pt=128B, lists based at 0.
  task automatic push_v2;
    for (int i = 0; i < 4; i++) begin
      logic [23:0] a;
      logic [31:0] c;
      a = 24'h2000 + 24'(24 * i);
      c = ((i == 3) ? 32'h8000_0000 : 32'h0) | 32'((i / 2) << 8) | 32'((i % 2) << 2);
      push(a, c);
      push(a + 24'd4,  32'(32'h20 * i));
      push(a + 24'd8,  32'h8000_0000);
      push(a + 24'd12, 32'(32'h80 + 32'h20 * i));
      push(a + 24'd16, 32'h8000_0000);
      push(a + 24'd20, 32'(32'h100 + 32'h80 * i));
`ifdef RA_BUILDER_OL_INIT_EN
      push(24'(32'h20 * i), 32'hF000_0000);
      push(24'(32'h80 + 32'h20 * i), 32'hF000_0000);
      push(24'(32'h100 + 32'h80 * i), 32'hF000_0000);
`endif
    end
  endtask

  task automatic cfg_v2;
    fpu = 32'h0020_0000; alloc = 32'h0003_0101; clip = 32'h0001_0001;
    region = 32'h2000; olb = 32'h0; pb = 32'h0;
  endtask

  initial begin
    int d0;
    logic [23:0] sa;
    logic [31:0] sd;
    // reset state
    repeat (3) tick;
    check("rst_wr", {31'd0, ra_vram_wr}, 32'd0);
    check("rst_addr", 32'(ra_vram_addr), 32'd0);
    check("rst_dout", ra_vram_dout, 32'd0);
    check("rst_busy", {31'd0, ra_busy}, 32'd0);
    check("rst_done", {31'd0, ra_done}, 32'd0);
    reset_n = 1'b1;
    tick;

    // v1 single tile, only o enabled
    fpu = 32'h0; alloc = 32'h1; clip = 32'h0; region = 32'h1000; olb = 32'h10_0000; pb = 32'h10_0000;
    push(24'h1000, 32'h8000_0000);
    push(24'h1004, 32'h0000_0000);
    push(24'h1008, 32'h8000_0000);
    push(24'h100C, 32'h8000_0000);
    push(24'h1010, 32'h8000_0000);
`ifdef RA_BUILDER_OL_INIT_EN
    push(24'h10_0000, 32'hF000_0000);
`endif
    acc_mark = acc_cnt; d0 = done_cnt;
    start;
    check("t1_busy_after_trig", {31'd0, ra_busy}, 32'd1);
    wait_done(d0, "t1");
`ifdef RA_BUILDER_OL_INIT_EN
    check("t1_done_lat", 32'(done_cyc - first_acc), 32'd7);
`else
    check("t1_done_lat", 32'(done_cyc - first_acc), 32'd6);
`endif

    // v2 2x2, no stall
    cfg_v2; push_v2;
    d0 = done_cnt;
    start;
    wait_done(d0, "t2");

    // same, 3-cycle stall on the second word
    push_v2;
    acc_mark = acc_cnt; d0 = done_cnt;
    start;
    for (int n = 0; n < 100 && acc_cnt == acc_mark; n++) tick;
    ra_vram_wait = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      if (k == 0) begin sa = ra_vram_addr; sd = ra_vram_dout; end
      check("stall_wr", {31'd0, ra_vram_wr}, 32'd1);
      check("stall_addr", 32'(ra_vram_addr), 32'h2004);
      check("stall_dout", ra_vram_dout, 32'h0);
      if (k != 0) begin
        check("stall_addr_hold", 32'(ra_vram_addr), 32'(sa));
        check("stall_dout_hold", ra_vram_dout, sd);
      end
      @(posedge clock);
    end
    #1 ra_vram_wait = 1'b0;
    wait_done(d0, "t3");

    // retrigger mid-build is ignored
    push_v2;
    d0 = done_cnt;
    start;
    repeat (10) tick;
    start;
    wait_done(d0, "t4");

    // reset mid-build, then clean rebuild
    push_v2;
    start;
    repeat (12) tick;
    reset_n = 1'b0;
    #1;
    check("mid_rst_wr", {31'd0, ra_vram_wr}, 32'd0);
    check("mid_rst_addr", 32'(ra_vram_addr), 32'd0);
    check("mid_rst_busy", {31'd0, ra_busy}, 32'd0);
    exp_q.delete();
    repeat (2) tick;
    reset_n = 1'b1;
    tick;
    push_v2;
    d0 = done_cnt;
    start;
    wait_done(d0, "t5");

    // all lists disabled, v1, 2x1 tiles
    fpu = 32'h0; alloc = 32'h0; clip = 32'h1; region = 32'h3000; olb = 32'h400; pb = 32'h0;
    for (int i = 0; i < 2; i++) begin
      push(24'h3000 + 24'(20 * i), (i == 1) ? 32'h8000_0004 : 32'h0);
      for (int w = 1; w < 5; w++) push(24'h3000 + 24'(20 * i + 4 * w), 32'h8000_0000);
    end
    d0 = done_cnt;
    start;
    wait_done(d0, "t6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
